// File: rtl/sram_arbiter_if.sv
// Bundle between the CPU fetch/data ports, the arbiter and sram_control.
// The arbiter uses the slave modport; the CPU/SRAM environment uses master.
interface sram_arbiter_if;
  logic        if_req_i;
  logic [19:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;

  logic        dm_req_i;
  logic [3:0]  dm_op_i;
  logic [19:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;

  logic        err_o;
  logic        if_stall_o;
  logic        dm_stall_o;

  logic [19:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_op_o;
  logic [31:0] ram_rdata_i;
  logic        ram_success_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  dm_req_i, dm_op_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_ack_o,
    output err_o, if_stall_o, dm_stall_o,
    output ram_addr_o, ram_wdata_o, ram_op_o,
    input  ram_rdata_i, ram_success_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output dm_req_i, dm_op_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_ack_o,
    input  err_o, if_stall_o, dm_stall_o,
    input  ram_addr_o, ram_wdata_o, ram_op_o,
    output ram_rdata_i, ram_success_i
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one sram_control between fetch (IF) and data (DM) ports.
// SRAM_ARB_RR_EN: round-robin on contention instead of DM priority.
module sram_arbiter #(
  parameter logic [3:0] IF_OP   = 4'b0001,
  parameter int         TIMEOUT = 15,
  parameter int         CNT_W   = 8
) (
  input logic         clk50,
  input logic         rst_n,
  sram_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             grant_dm;
  logic             pick_dm;
  logic             pick_if;
  logic             timeout;

  logic [3:0]  ram_op;
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] if_rdata;
  logic [31:0] dm_rdata;
  logic        if_ack;
  logic        dm_ack;
  logic        err;

`ifdef SRAM_ARB_RR_EN
  logic last_dm;

  always_comb begin
    pick_dm = bus.dm_req_i & ~(bus.if_req_i & last_dm);
    pick_if = bus.if_req_i & ~pick_dm;
  end
`else
  always_comb begin
    pick_dm = bus.dm_req_i;
    pick_if = bus.if_req_i & ~pick_dm;
  end
`endif

  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

  assign bus.ram_op_o    = ram_op;
  assign bus.ram_addr_o  = ram_addr;
  assign bus.ram_wdata_o = ram_wdata;
  assign bus.if_rdata_o  = if_rdata;
  assign bus.dm_rdata_o  = dm_rdata;
  assign bus.if_ack_o    = if_ack;
  assign bus.dm_ack_o    = dm_ack;
  assign bus.err_o       = err;
  assign bus.if_stall_o  = bus.if_req_i & ~if_ack;
  assign bus.dm_stall_o  = bus.dm_req_i & ~dm_ack;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      grant_dm  <= 1'b0;
      ram_op    <= 4'd0;
      ram_addr  <= 20'd0;
      ram_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      dm_rdata  <= 32'd0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      err       <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_dm   <= 1'b0;
`endif
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      err    <= 1'b0;
      unique case (state)
        IDLE: begin
          ram_op <= 4'd0;
          cnt    <= '0;
          unique case (1'b1)
            pick_dm: begin
              ram_op    <= bus.dm_op_i;
              ram_addr  <= bus.dm_addr_i;
              ram_wdata <= bus.dm_wdata_i;
              grant_dm  <= 1'b1;
              state     <= BUSY;
`ifdef SRAM_ARB_RR_EN
              last_dm   <= 1'b1;
`endif
            end
            pick_if: begin
              ram_op    <= IF_OP;
              ram_addr  <= bus.if_addr_i;
              ram_wdata <= 32'd0;
              grant_dm  <= 1'b0;
              state     <= BUSY;
`ifdef SRAM_ARB_RR_EN
              last_dm   <= 1'b0;
`endif
            end
            default: ;
          endcase
        end
        BUSY: begin
          if (bus.ram_success_i || timeout) begin
            // an aborted transaction still acks, but with zeroed data
            if (grant_dm) begin
              dm_rdata <= bus.ram_success_i ? bus.ram_rdata_i : 32'd0;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= bus.ram_success_i ? bus.ram_rdata_i : 32'd0;
              if_ack   <= 1'b1;
            end
            err    <= ~bus.ram_success_i;
            ram_op <= 4'd0;
            cnt    <= '0;
            state  <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
